// File: rtl/ysyx_23060236_axi_rslave.sv
// ysyx_23060236_axi_rslave
//   AXI-style read-only slave that serves bursts from a single-cycle-latency
//   backing memory. Supports FIXED, INCR and WRAP bursts of 1..16 beats, and
//   flags beats outside [BASE_ADDR, BASE_ADDR+SIZE) or with an illegal burst
//   setup with SLVERR (data forced to zero, no memory read).
//
//   Optional feature: define YSYX_23060236_RSLAVE_DELAY_EN to insert DELAY
//   wait cycles (WAIT state) before every memory read. Without the macro the
//   WAIT state and its counter do not exist.
//
// Ports
//   clock, reset            single clock, synchronous active-high reset
//   araddr/arvalid/arready  burst start address handshake
//   arburst, arlen          burst type and beat count minus one
//   rdata/rresp/rlast       read beat payload
//   rvalid/rready           read beat handshake
//   mem_ren, mem_addr       backing-memory read strobe and word address
//   mem_rdata               memory data, valid one cycle after mem_ren
module ysyx_23060236_axi_rslave #(
   parameter logic [31:0] BASE_ADDR = 32'h30000000,
   parameter logic [31:0] SIZE      = 32'h01000000,
   parameter int unsigned DELAY     = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] araddr,
   input  logic        arvalid,
   output logic        arready,
   input  logic [1:0]  arburst,
   input  logic [3:0]  arlen,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready,
   output logic        mem_ren,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [2:0] {
      IDLE,
`ifdef YSYX_23060236_RSLAVE_DELAY_EN
      WAIT,
`endif
      FETCH,
      CAPT,
      RESP
   } state_t;

   localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + {1'b0, SIZE};

   state_t      state, state_n, first_state;
   logic [31:0] addr_q;
   logic [1:0]  burst_q;
   logic [3:0]  len_q;
   logic [3:0]  beat_q;
   logic [31:0] rdata_q;
   logic [1:0]  rresp_q;
   logic        rlast_q;
   logic        rvalid_q;
   logic        burst_bad;
   logic        in_range;
   logic        beat_err;
   logic [31:0] wrap_mask;
   logic [31:0] addr_inc;
   logic [31:0] addr_next;
   logic        unused_bits;

`ifdef YSYX_23060236_RSLAVE_DELAY_EN
   logic [31:0] cnt_q;
   assign first_state = (DELAY == 0) ? FETCH : WAIT;
`else
   assign first_state = FETCH;
`endif

   // Byte-offset bits of araddr are dropped; DELAY is only consumed by the
   // optional wait path.
   assign unused_bits = ^{araddr[1:0], DELAY};

   // Illegal setups make every beat of the burst an error beat.
   assign burst_bad = (burst_q == 2'b11) ||
                      ((burst_q == 2'b10) &&
                       !((len_q == 4'd1) || (len_q == 4'd3) ||
                         (len_q == 4'd7) || (len_q == 4'd15)));
   assign in_range  = (addr_q >= BASE_ADDR) && ({1'b0, addr_q} < LIMIT);
   assign beat_err  = burst_bad || !in_range;

   // For legal WRAP lengths (len+1 a power of two) the window byte mask is
   // simply {len, 2'b11}; the low bits wrap while the high bits hold.
   assign wrap_mask = {26'd0, len_q, 2'b11};
   assign addr_inc  = addr_q + 32'd4;

   always_comb begin
      addr_next = addr_inc;
      case (burst_q)
         2'b00:   addr_next = addr_q;
         2'b10:   addr_next = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
         default: addr_next = addr_inc;
      endcase
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:  if (arvalid) state_n = first_state;
`ifdef YSYX_23060236_RSLAVE_DELAY_EN
         WAIT:  if (cnt_q == '0) state_n = FETCH;
`endif
         FETCH: state_n = CAPT;
         CAPT:  state_n = RESP;
         RESP:  if (rready) state_n = rlast_q ? IDLE : first_state;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         addr_q   <= '0;
         burst_q  <= '0;
         len_q    <= '0;
         beat_q   <= '0;
         rdata_q  <= '0;
         rresp_q  <= '0;
         rlast_q  <= 1'b0;
         rvalid_q <= 1'b0;
`ifdef YSYX_23060236_RSLAVE_DELAY_EN
         cnt_q    <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (arvalid) begin
                  addr_q  <= {araddr[31:2], 2'b00};
                  burst_q <= arburst;
                  len_q   <= arlen;
                  beat_q  <= '0;
`ifdef YSYX_23060236_RSLAVE_DELAY_EN
                  cnt_q   <= DELAY - 1;
`endif
               end
            end
`ifdef YSYX_23060236_RSLAVE_DELAY_EN
            WAIT: begin
               if (cnt_q != '0) cnt_q <= cnt_q - 32'd1;
            end
`endif
            CAPT: begin
               rdata_q  <= beat_err ? '0 : mem_rdata;
               rresp_q  <= beat_err ? 2'b10 : 2'b00;
               rlast_q  <= (beat_q == len_q);
               rvalid_q <= 1'b1;
            end
            RESP: begin
               if (rready) begin
                  rvalid_q <= 1'b0;
                  if (rlast_q) begin
                     rlast_q <= 1'b0;
                  end else begin
                     beat_q <= beat_q + 4'd1;
                     addr_q <= addr_next;
`ifdef YSYX_23060236_RSLAVE_DELAY_EN
                     cnt_q  <= DELAY - 1;
`endif
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign arready  = (state == IDLE);
   assign mem_ren  = (state == FETCH) && !beat_err;
   assign mem_addr = addr_q;
   assign rdata    = rdata_q;
   assign rresp    = rresp_q;
   assign rlast    = rlast_q;
   assign rvalid   = rvalid_q;

endmodule

// File: tb/tb_ysyx_23060236_axi_rslave.sv
// tb_ysyx_23060236_axi_rslave
//   Directed bench for ysyx_23060236_axi_rslave: each burst pushes its
//   expected beats and memory fetch addresses into queues, which are popped
//   as the DUT produces mem_ren strobes and R handshakes.
module tb_ysyx_23060236_axi_rslave;

   localparam logic [31:0] BASE = 32'h30000000;
   localparam logic [31:0] SZ   = 32'h01000000;
`ifdef YSYX_23060236_RSLAVE_DELAY_EN
   localparam int D = 4;
`else
   localparam int D = 0;
`endif

   logic        clock;
   logic        reset;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [1:0]  arburst;
   logic [3:0]  arlen;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic        mem_ren;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } beat_t;

   beat_t       exp_q[$];
   logic [31:0] fetch_q[$];
   int          n_asrt;
   int          n_fail;

   ysyx_23060236_axi_rslave #(
      .BASE_ADDR(BASE),
      .SIZE(SZ),
      .DELAY(4)
   ) u_dut (
      .clock(clock),
      .reset(reset),
      .araddr(araddr),
      .arvalid(arvalid),
      .arready(arready),
      .arburst(arburst),
      .arlen(arlen),
      .rdata(rdata),
      .rresp(rresp),
      .rlast(rlast),
      .rvalid(rvalid),
      .rready(rready),
      .mem_ren(mem_ren),
      .mem_addr(mem_addr),
      .mem_rdata(mem_rdata)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5AC3C3;
   endfunction

   // Backing memory: data appears one cycle after the strobe; junk otherwise.
   always @(posedge clock) begin
      if (mem_ren) mem_rdata <= memf(mem_addr);
      else         mem_rdata <= 32'hDEADBEEF;
   end

   function automatic logic [31:0] nxt(input logic [31:0] a, input logic [1:0] bt,
                                       input logic [3:0] len);
      logic [31:0] w;
      logic [31:0] base;
      case (bt)
         2'b00: return a;
         2'b10: begin
            w    = (32'(len) + 32'd1) * 32'd4;
            base = (a / w) * w;
            return base + ((a - base + 32'd4) % w);
         end
         default: return a + 32'd4;
      endcase
   endfunction

   function automatic logic is_err(input logic [31:0] a, input logic [1:0] bt,
                                   input logic [3:0] len);
      logic [32:0] lim;
      lim = {1'b0, BASE} + {1'b0, SZ};
      if (bt == 2'b11) return 1'b1;
      if (bt == 2'b10 && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15))
         return 1'b1;
      return (a < BASE) || ({1'b0, a} >= lim);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_arready"}, 64'(arready), 64'd1);
      chk({tag, "_rvalid"},  64'(rvalid),  64'd0);
      chk({tag, "_rlast"},   64'(rlast),   64'd0);
      chk({tag, "_rresp"},   64'(rresp),   64'd0);
      chk({tag, "_rdata"},   64'(rdata),   64'd0);
      chk({tag, "_mem_ren"}, 64'(mem_ren), 64'd0);
      chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
   endtask

   // Called at a negedge; returns at the negedge right after the burst ends.
   task automatic burst(input logic [31:0] a0, input logic [1:0] bt, input logic [3:0] len,
                        input int stall_beat, input int stall_n, input int rst_beat);
      logic [31:0] a;
      logic        e;
      beat_t       b;
      beat_t       got;
      int          cyc;
      int          hs_cyc;
      int          beat;
      int          stall_left;
      logic        seen_valid;
      logic        done;
      logic [34:0] snap;

      a = {a0[31:2], 2'b00};
      for (int i = 0; i <= int'(len); i++) begin
         e      = is_err(a, bt, len);
         b.data = e ? 32'd0 : memf(a);
         b.resp = e ? 2'b10 : 2'b00;
         b.last = (i == int'(len));
         exp_q.push_back(b);
         if (!e) fetch_q.push_back(a);
         a = nxt(a, bt, len);
      end

      araddr  = a0;
      arburst = bt;
      arlen   = len;
      arvalid = 1'b1;
      rready  = 1'b1;
      chk("arready_idle", 64'(arready), 64'd1);
      @(negedge clock);
      arvalid = 1'b0;
      araddr  = $urandom;

      cyc        = 1;
      hs_cyc     = 0;
      beat       = 0;
      stall_left = stall_n;
      seen_valid = 1'b0;
      done       = 1'b0;
      snap       = '0;
      while (!done) begin
         if (cyc > 400) begin
            chk("timeout", 64'd0, 64'd1);
            exp_q.delete();
            fetch_q.delete();
            return;
         end
         if (rst_beat >= 0 && rvalid && beat == rst_beat) begin
            reset  = 1'b1;
            rready = 1'b0;
            @(negedge clock);
            chk_reset_vals("midrst");
            @(negedge clock);
            chk_reset_vals("midrst_hold");
            reset = 1'b0;
            exp_q.delete();
            fetch_q.delete();
            for (int k = 0; k < 6; k++) begin
               @(negedge clock);
               chk("postrst_rvalid", 64'(rvalid), 64'd0);
               chk("postrst_ren", 64'(mem_ren), 64'd0);
               chk("postrst_arready", 64'(arready), 64'd1);
            end
            rready = 1'b1;
            return;
         end
         chk("arready_busy", 64'(arready), 64'd0);
         if (mem_ren) begin
            if (fetch_q.size() == 0) chk("spurious_ren", 64'd1, 64'd0);
            else chk("mem_addr", 64'(mem_addr), 64'(fetch_q.pop_front()));
            chk("ren_latency", 64'(cyc - hs_cyc), 64'(1 + D));
         end
         rready = 1'b1;
         if (rvalid) begin
            if (!seen_valid) begin
               chk("rvalid_latency", 64'(cyc - hs_cyc), 64'(3 + D));
               seen_valid = 1'b1;
            end
            if (beat == stall_beat && stall_left > 0) begin
               if (stall_left == stall_n) snap = {rdata, rresp, rlast};
               else chk("stall_hold", 64'({rdata, rresp, rlast}), 64'(snap));
               chk("stall_ren", 64'(mem_ren), 64'd0);
               rready = 1'b0;
               stall_left--;
            end else if (exp_q.size() == 0) begin
               chk("extra_beat", 64'd1, 64'd0);
               done = 1'b1;
            end else begin
               got = exp_q.pop_front();
               chk("rdata", 64'(rdata), 64'(got.data));
               chk("rresp", 64'(rresp), 64'(got.resp));
               chk("rlast", 64'(rlast), 64'(got.last));
               beat++;
               hs_cyc     = cyc;
               seen_valid = 1'b0;
               if (got.last) done = 1'b1;
            end
         end
         @(negedge clock);
         cyc++;
      end
      chk("end_arready", 64'(arready), 64'd1);
      chk("end_rvalid", 64'(rvalid), 64'd0);
      chk("end_rlast", 64'(rlast), 64'd0);
      chk("end_ren", 64'(mem_ren), 64'd0);
      chk("end_fetch_left", 64'(fetch_q.size()), 64'd0);
      chk("end_beats_left", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      fetch_q.delete();
   endtask

   initial begin
      n_asrt    = 0;
      n_fail    = 0;
      reset     = 1'b1;
      araddr    = '0;
      arvalid   = 1'b0;
      arburst   = '0;
      arlen     = '0;
      rready    = 1'b0;
      mem_rdata = '0;
      repeat (3) @(negedge clock);
      chk_reset_vals("reset");
      reset = 1'b0;
      @(negedge clock);

      burst(32'h30000010, 2'b01, 4'd7,  -1, 0, -1);  // INCR 8 beats
      burst(32'h30000018, 2'b10, 4'd3,  -1, 0, -1);  // WRAP 4 beats
      burst(32'h30FFFFF8, 2'b01, 4'd3,  -1, 0, -1);  // crosses top of range
      burst(32'h2FFFFFF8, 2'b01, 4'd3,  -1, 0, -1);  // enters range from below
      burst(32'h30000100, 2'b01, 4'd3,   1, 5, -1);  // 5-cycle stall on beat 2
      burst(32'h30000040, 2'b00, 4'd3,  -1, 0, -1);  // FIXED
      burst(32'h3000003C, 2'b10, 4'd7,  -1, 0, -1);  // WRAP 8, wraps on beat 2
      burst(32'h30000234, 2'b10, 4'd15, -1, 0, -1);  // WRAP 16
      burst(32'h30000020, 2'b10, 4'd2,  -1, 0, -1);  // illegal WRAP length
      burst(32'h30000020, 2'b11, 4'd1,  -1, 0, -1);  // reserved burst type
      burst(32'h30000200, 2'b01, 4'd15, -1, 0, -1);  // INCR 16
      burst(32'h30000303, 2'b01, 4'd0,  -1, 0, -1);  // single beat, low bits set
      burst(32'h30000000, 2'b01, 4'd7,  -1, 0,  2);  // reset during beat 3
      burst(32'h30000080, 2'b01, 4'd1,  -1, 0, -1);  // clean restart

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
